// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with cycle lock and bus watchdog.
// Ports: m0/m1 master buses, s_* slave bus, wb_clk_i, async active-low wb_rst_ni.
module wb_arbiter_2m #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_gnt_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_gnt_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i
);

  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blk_q, blk_d;
  logic             own_stb;
  logic             wd_fire;
  logic             pick0, pick1;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Exclusive picks: on a tie the master not granted last time wins.
  assign pick0 = m0_cyc_i & (~m1_cyc_i | last_gnt_q);
  assign pick1 = m1_cyc_i & (~m0_cyc_i | ~last_gnt_q);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick0: begin
            state_d    = GNT0;
            last_gnt_d = 1'b0;
          end
          pick1: begin
            state_d    = GNT1;
            last_gnt_d = 1'b1;
          end
          default: ;
        endcase
      end
      GNT0: if (!m0_cyc_i) state_d = IDLE;
      GNT1: if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slave mux; blk_q masks stb after a watchdog abort.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    own_stb  = 1'b0;
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    unique case (state_q)
      GNT0: begin
        m0_gnt_o = 1'b1;
        own_stb  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_cyc_i & m0_stb_i & ~blk_q;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
      end
      GNT1: begin
        m1_gnt_o = 1'b1;
        own_stb  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_cyc_i & m1_stb_i & ~blk_q;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
      end
      default: ;
    endcase
  end

  assign wd_fire = WD_EN & (cnt_q == WD_LAST) & s_stb_o
                 & ~s_ack_i & ~s_err_i;

  assign m0_ack_o = m0_gnt_o & s_ack_i;
  assign m1_ack_o = m1_gnt_o & s_ack_i;
  assign m0_err_o = m0_gnt_o & (s_err_i | wd_fire);
  assign m1_err_o = m1_gnt_o & (s_err_i | wd_fire);

  always_comb begin
    cnt_d = cnt_q;
    blk_d = blk_q;
    if (state_q == IDLE || !s_stb_o || s_ack_i
        || s_err_i || wd_fire) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (wd_fire) begin
      blk_d = 1'b1;
    end else if (state_q == IDLE || !own_stb) begin
      blk_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      blk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
    end
  end

endmodule
